// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode set, ALU function
// encodings, FSM state encoding and small opcode classification helpers.
package instr_sequencer_pkg;

  // Opcode nibble carried in the upper half of each instruction byte
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LIT   = 4'h1,
    OP_IN    = 4'h2,
    OP_ADDI  = 4'h3,
    OP_SUBI  = 4'h4,
    OP_CMPI  = 4'h5,
    OP_NANDI = 4'h6,
    OP_OUT   = 4'h7,
    OP_JMP   = 4'h8,
    OP_JC    = 4'h9,
    OP_JNC   = 4'hA,
    OP_JZ    = 4'hB,
    OP_JNZ   = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_t;

  // ALU function select values
  localparam logic [2:0] ALU_PASS_BUS = 3'b000;
  localparam logic [2:0] ALU_SUB      = 3'b001;
  localparam logic [2:0] ALU_PASS_ACC = 3'b010;
  localparam logic [2:0] ALU_ADD      = 3'b011;
  localparam logic [2:0] ALU_NAND     = 3'b100;

  // Sequencer FSM state encoding
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_JADDR = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // Opcodes that are followed by a low-address byte
  function automatic logic is_jump(input logic [3:0] op);
    return (op >= OP_JMP) && (op <= OP_JNZ);
  endfunction

  // Opcodes whose EXEC cycle captures the ALU carry/zero outputs
  function automatic logic sets_flags(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/status bundle between the sequencer and the datapath it steers.
// The master side is the sequencer; the slave side is the datapath.
interface instr_sequencer_if;
  logic [3:0]  INSTR;
  logic [3:0]  OPER;
  logic [7:0]  PROG_DATA;
  logic        C_IN;
  logic        Z_IN;
  logic        PC_INC;
  logic        PC_LOAD;
  logic [11:0] PC_ADDR;
  logic        FETCH_EN;
  logic        ACC_EN;
  logic [2:0]  ALU_SEL;
  logic        BUS_IN_EN;
  logic        BUS_OUT_EN;
  logic        IN_SEL;
  logic        OUT_EN;
  logic        C_FLAG;
  logic        Z_FLAG;
  logic        HALTED;

  modport master (
    input  INSTR, OPER, PROG_DATA, C_IN, Z_IN,
    output PC_INC, PC_LOAD, PC_ADDR, FETCH_EN, ACC_EN, ALU_SEL,
           BUS_IN_EN, BUS_OUT_EN, IN_SEL, OUT_EN, C_FLAG, Z_FLAG, HALTED
  );

  modport slave (
    output INSTR, OPER, PROG_DATA, C_IN, Z_IN,
    input  PC_INC, PC_LOAD, PC_ADDR, FETCH_EN, ACC_EN, ALU_SEL,
           BUS_IN_EN, BUS_OUT_EN, IN_SEL, OUT_EN, C_FLAG, Z_FLAG, HALTED
  );
endinterface

// File: rtl/instr_sequencer_cond_eval.sv
// Jump condition evaluation: decides whether a jump opcode is taken given the
// registered carry and zero flags. Non-jump opcodes are never taken.
module cond_eval
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] op,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       take
);

  // Condition decode per jump opcode
  always_comb begin
    take = 1'b0;
    case (op)
      OP_JMP:  take = 1'b1;
      OP_JC:   take = c_flag;
      OP_JNC:  take = ~c_flag;
      OP_JZ:   take = z_flag;
      OP_JNZ:  take = ~z_flag;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer for a small 4-bit accumulator machine. Walks the
// INIT -> FETCH -> EXEC (-> JADDR) cycle, decodes the fetched opcode into
// datapath strobes and keeps the carry/zero flags used by conditional jumps.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [11:0] RESET_VECTOR = 12'h000
) (
  input  logic               CLK,
  input  logic               RST,
  instr_sequencer_if.master  io
);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic        c_flag;
  logic        z_flag;
  logic        take;
  opcode_t     op;

  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_addr;
  logic        fetch_en;
  logic        acc_en;
  logic [2:0]  alu_sel;
  logic        bus_in_en;
  logic        bus_out_en;
  logic        in_sel;
  logic        out_en;

  // The fetch register holds the opcode through EXEC and JADDR
  assign op = opcode_t'(io.INSTR);

  cond_eval u_cond_eval (
    .op     (io.INSTR),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .take   (take)
  );

  // State register; reset forces INIT so the first cycle after release loads the PC
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Flag register; only arithmetic/compare opcodes update it at the end of EXEC
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (state == ST_EXEC && sets_flags(io.INSTR)) begin
      c_flag <= io.C_IN;
      z_flag <= io.Z_IN;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = ST_INIT;
    case (state)
      ST_INIT:  state_next = ST_FETCH;
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_HALT) begin
          state_next = ST_HALT;
        end else if (is_jump(io.INSTR)) begin
          state_next = ST_JADDR;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_JADDR: state_next = ST_FETCH;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_INIT;
    endcase
  end

  // Strobe decode from state and opcode; everything is held quiet while in reset
  always_comb begin
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_addr    = '0;
    fetch_en   = 1'b0;
    acc_en     = 1'b0;
    alu_sel    = ALU_PASS_BUS;
    bus_in_en  = 1'b0;
    bus_out_en = 1'b0;
    in_sel     = 1'b0;
    out_en     = 1'b0;
    if (RST) begin
      case (state)
        ST_INIT: begin
          pc_load = 1'b1;
          pc_addr = RESET_VECTOR;
        end
        ST_FETCH: begin
          fetch_en = 1'b1;
          pc_inc   = 1'b1;
        end
        ST_EXEC: begin
          case (op)
            OP_LIT: begin
              bus_in_en = 1'b1;
              alu_sel   = ALU_PASS_BUS;
              acc_en    = 1'b1;
            end
            OP_IN: begin
              bus_in_en = 1'b1;
              in_sel    = 1'b1;
              alu_sel   = ALU_PASS_BUS;
              acc_en    = 1'b1;
            end
            OP_ADDI: begin
              bus_in_en = 1'b1;
              alu_sel   = ALU_ADD;
              acc_en    = 1'b1;
            end
            OP_SUBI: begin
              bus_in_en = 1'b1;
              alu_sel   = ALU_SUB;
              acc_en    = 1'b1;
            end
            OP_CMPI: begin
              bus_in_en = 1'b1;
              alu_sel   = ALU_SUB;
            end
            OP_NANDI: begin
              bus_in_en = 1'b1;
              alu_sel   = ALU_NAND;
              acc_en    = 1'b1;
            end
            OP_OUT: begin
              alu_sel    = ALU_PASS_ACC;
              bus_out_en = 1'b1;
              out_en     = 1'b1;
            end
            default: begin
            end
          endcase
        end
        ST_JADDR: begin
          // PC already points at the address byte; a skipped jump steps over it
          if (take) begin
            pc_load = 1'b1;
            pc_addr = {io.OPER, io.PROG_DATA};
          end else begin
            pc_inc = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io.PC_INC     = pc_inc;
  assign io.PC_LOAD    = pc_load;
  assign io.PC_ADDR    = pc_addr;
  assign io.FETCH_EN   = fetch_en;
  assign io.ACC_EN     = acc_en;
  assign io.ALU_SEL    = alu_sel;
  assign io.BUS_IN_EN  = bus_in_en;
  assign io.BUS_OUT_EN = bus_out_en;
  assign io.IN_SEL     = in_sel;
  assign io.OUT_EN     = out_en;
  assign io.C_FLAG     = c_flag;
  assign io.Z_FLAG     = z_flag;
  assign io.HALTED     = RST && (state == ST_HALT);

endmodule
